tri_raster: RTL

- Self-scanning triangle rasteriser for the graphics pipeline. It replaces the interface-driven draw path.
- Latches three vertices and a colour on `start`, then walks the clipped bounding box itself, one candidate pixel per cycle.
- Edge functions are evaluated incrementally; there are no per-pixel multiplies.
- Covered pixels are emitted on a valid/ready pixel stream to the framebuffer writer, with a one-cycle `done` pulse at the end.

---
 rtl/tri_raster_pkg.sv | 27 ++
 rtl/tri_raster_edge_stepper.sv | 48 ++++
 rtl/tri_raster.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/tri_raster_pkg.sv
// Shared types and helpers for the self-scanning triangle rasteriser.
// EW is sized for the package coordinate width; instances use WIDTH == COORD_W.
package tri_raster_pkg;

  localparam int COORD_W = 8;
  localparam int EW      = 2 * COORD_W + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Edge function of edge (i -> j) evaluated at point (px, py).
  function automatic logic signed [EW-1:0] edge_value(
    input logic signed [EW-1:0] px,
    input logic signed [EW-1:0] py,
    input logic signed [EW-1:0] xi,
    input logic signed [EW-1:0] yi,
    input logic signed [EW-1:0] xj,
    input logic signed [EW-1:0] yj
  );
    return (px - xi) * (yj - yi) - (py - yi) * (xj - xi);
  endfunction

endpackage

// File: rtl/tri_raster_edge_stepper.sv
// One incrementally-stepped edge function: current value plus row-start value.
module edge_stepper
  import tri_raster_pkg::*;
(
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_load,
  input  logic                 i_step_x,
  input  logic                 i_step_row,
  input  logic signed [EW-1:0] i_init_val,
  input  logic signed [EW-1:0] i_dx_step,
  input  logic signed [EW-1:0] i_dy_step,
  output logic                 o_neg,
  output logic                 o_zero
);

  logic signed [EW-1:0] r_val;
  logic signed [EW-1:0] r_row;
  logic signed [EW-1:0] r_dx;
  logic signed [EW-1:0] r_dy;
  logic signed [EW-1:0] w_next_row;

  assign w_next_row = r_row + r_dy;

  // A row step restarts the scan value from the advanced row-start value.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_val <= '0;
      r_row <= '0;
      r_dx  <= '0;
      r_dy  <= '0;
    end else if (i_load) begin
      r_val <= i_init_val;
      r_row <= i_init_val;
      r_dx  <= i_dx_step;
      r_dy  <= i_dy_step;
    end else if (i_step_row) begin
      r_val <= w_next_row;
      r_row <= w_next_row;
    end else if (i_step_x) begin
      r_val <= r_val + r_dx;
    end
  end

  assign o_neg  = r_val[EW-1];
  assign o_zero = (r_val == '0);

endmodule

// File: rtl/tri_raster.sv
// Self-scanning triangle rasteriser: latches vertices on start, walks the clipped
// bounding box one pixel per cycle. Optional macro: TRI_RASTER_BACKFACE_CULL_EN.
module tri_raster
  import tri_raster_pkg::*;
#(
  parameter int WIDTH        = COORD_W,
  parameter int COLOUR_WIDTH = 3,
  parameter int SCREEN_W     = 160,
  parameter int SCREEN_H     = 120
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WIDTH-1:0]        ax,
  input  logic [WIDTH-1:0]        ay,
  input  logic [WIDTH-1:0]        bx,
  input  logic [WIDTH-1:0]        by,
  input  logic [WIDTH-1:0]        cx,
  input  logic [WIDTH-1:0]        cy,
  input  logic [COLOUR_WIDTH-1:0] colour,
  output logic                    busy,
  output logic                    done,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [WIDTH-1:0]        pix_x,
  output logic [WIDTH-1:0]        pix_y,
  output logic [COLOUR_WIDTH-1:0] pix_colour,
  output state_t                  dbg_state
);

  localparam logic [WIDTH-1:0] X_LIM = WIDTH'(SCREEN_W - 1);
  localparam logic [WIDTH-1:0] Y_LIM = WIDTH'(SCREEN_H - 1);
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] min3(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [WIDTH-1:0] max3(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic signed [EW-1:0] ext(input logic [WIDTH-1:0] v);
    return $signed({{(EW-WIDTH){1'b0}}, v});
  endfunction

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]        r_ax, r_ay, r_bx, r_by, r_cx, r_cy;
  logic [COLOUR_WIDTH-1:0] r_colour;
  logic [WIDTH-1:0]        r_x, r_y;
  logic [WIDTH-1:0]        r_xmin, r_xmax, r_ymax;

  logic                    w_latch, w_load, w_step_x, w_step_row;
  logic [WIDTH-1:0]        w_xmin, w_ymin, w_xmax_raw, w_ymax_raw, w_xmax, w_ymax;
  logic                    w_box_empty, w_reject, w_inside, w_last_col, w_last_row;
  logic signed [EW-1:0]    w_area2, w_xmin_e, w_ymin_e;
  logic signed [EW-1:0]    w_vx [3];
  logic signed [EW-1:0]    w_vy [3];
  logic signed [EW-1:0]    w_init [3];
  logic signed [EW-1:0]    w_dx [3];
  logic signed [EW-1:0]    w_dy [3];
  logic [2:0]              w_neg, w_zero;

  // Setup arithmetic works from the latched vertices only.
  assign w_xmin     = min3(r_ax, r_bx, r_cx);
  assign w_ymin     = min3(r_ay, r_by, r_cy);
  assign w_xmax_raw = max3(r_ax, r_bx, r_cx);
  assign w_ymax_raw = max3(r_ay, r_by, r_cy);
  assign w_xmax     = (w_xmax_raw > X_LIM) ? X_LIM : w_xmax_raw;
  assign w_ymax     = (w_ymax_raw > Y_LIM) ? Y_LIM : w_ymax_raw;
  assign w_box_empty = (w_xmin > w_xmax) || (w_ymin > w_ymax);

  assign w_vx[0] = ext(r_ax);
  assign w_vy[0] = ext(r_ay);
  assign w_vx[1] = ext(r_bx);
  assign w_vy[1] = ext(r_by);
  assign w_vx[2] = ext(r_cx);
  assign w_vy[2] = ext(r_cy);
  assign w_xmin_e = ext(w_xmin);
  assign w_ymin_e = ext(w_ymin);

  assign w_area2 = (w_vx[1] - w_vx[0]) * (w_vy[2] - w_vy[0])
                 - (w_vy[1] - w_vy[0]) * (w_vx[2] - w_vx[0]);

`ifdef TRI_RASTER_BACKFACE_CULL_EN
  assign w_reject = (w_area2 == '0) || w_area2[EW-1];
`else
  assign w_reject = (w_area2 == '0);
`endif

  // Edges AB, BC, CA; stepping x adds (yj-yi), stepping a row adds (xi-xj).
  for (genvar g = 0; g < 3; g++) begin : g_edge
    localparam int J = (g + 1) % 3;
    assign w_init[g] = edge_value(w_xmin_e, w_ymin_e, w_vx[g], w_vy[g], w_vx[J], w_vy[J]);
    assign w_dx[g]   = w_vy[J] - w_vy[g];
    assign w_dy[g]   = w_vx[g] - w_vx[J];

    edge_stepper u_edge (
      .i_clock    (clock),
      .i_reset    (reset),
      .i_load     (w_load),
      .i_step_x   (w_step_x),
      .i_step_row (w_step_row),
      .i_init_val (w_init[g]),
      .i_dx_step  (w_dx[g]),
      .i_dy_step  (w_dy[g]),
      .o_neg      (w_neg[g]),
      .o_zero     (w_zero[g])
    );
  end

  // Winding-independent, inclusive coverage test.
  assign w_inside   = (&(~w_neg)) || (&(w_neg | w_zero));
  assign w_last_col = (r_x == r_xmax);
  assign w_last_row = (r_y == r_ymax);

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_latch    = 1'b0;
    w_load     = 1'b0;
    w_step_x   = 1'b0;
    w_step_row = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_latch = 1'b1;
          w_next  = SETUP;
        end
      end
      SETUP: begin
        w_load = 1'b1;
        w_next = (w_reject || w_box_empty) ? DONE : SCAN;
      end
      SCAN: begin
        // A covered pixel holds the scan until the consumer takes it.
        if (!w_inside || pix_ready) begin
          if (!w_last_col)      w_step_x   = 1'b1;
          else if (!w_last_row) w_step_row = 1'b1;
          else                  w_next     = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ax     <= '0;
      r_ay     <= '0;
      r_bx     <= '0;
      r_by     <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_colour <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_xmin   <= '0;
      r_xmax   <= '0;
      r_ymax   <= '0;
    end else begin
      if (w_latch) begin
        r_ax     <= ax;
        r_ay     <= ay;
        r_bx     <= bx;
        r_by     <= by;
        r_cx     <= cx;
        r_cy     <= cy;
        r_colour <= colour;
      end
      if (w_load) begin
        r_x    <= w_xmin;
        r_y    <= w_ymin;
        r_xmin <= w_xmin;
        r_xmax <= w_xmax;
        r_ymax <= w_ymax;
      end else if (w_step_row) begin
        r_x <= r_xmin;
        r_y <= r_y + ONE;
      end else if (w_step_x) begin
        r_x <= r_x + ONE;
      end
    end
  end

  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);
  assign pix_valid  = (r_state == SCAN) && w_inside;
  assign pix_x      = r_x;
  assign pix_y      = r_y;
  assign pix_colour = r_colour;
  assign dbg_state  = r_state;

endmodule
